// File: rtl/cmult_rr_scheduler_if.sv
// Requester, multiplier and result signals of the shared complex-multiplier scheduler.
// The slave modport is the scheduler; the master modport is its environment.
interface cmult_rr_scheduler_if #(
  parameter int WIDTH_R_I = 16,
  parameter int NUM_REQ   = 3
);
  localparam int OPW  = 2 * WIDTH_R_I;
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*OPW-1:0] req_a;
  logic [NUM_REQ*OPW-1:0] req_b;
  logic [NUM_REQ-1:0]     req_ready;
  logic [OPW-1:0]         mult_a;
  logic [OPW-1:0]         mult_b;
  logic                   mult_en;
  logic [2*OPW-1:0]       mult_out;
  logic                   res_valid;
  logic                   res_ready;
  logic [2*OPW-1:0]       res_data;
  logic [ID_W-1:0]        res_id;

  modport slave (
    input  req_valid, req_a, req_b, mult_out, res_ready,
    output req_ready, mult_a, mult_b, mult_en, res_valid, res_data, res_id
  );

  modport master (
    output req_valid, req_a, req_b, mult_out, res_ready,
    input  req_ready, mult_a, mult_b, mult_en, res_valid, res_data, res_id
  );
endinterface

// File: rtl/cmult_rr_scheduler.sv
// Round-robin scheduler sharing one combinational complex multiplier among NUM_REQ
// requesters, with bounded burst ownership and a one-entry registered result stage.
module cmult_rr_scheduler #(
  parameter int WIDTH_R_I = 16,
  parameter int NUM_REQ   = 3,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  cmult_rr_scheduler_if.slave bus
);
  localparam int OPW   = 2 * WIDTH_R_I;
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic               owner_vld_r;
  logic [ID_W-1:0]    owner_r;
  logic [CNT_W-1:0]   burst_cnt_r;
  logic [ID_W-1:0]    rr_ptr_r;
  logic               res_valid_r;
  logic [2*OPW-1:0]   res_data_r;
  logic [ID_W-1:0]    res_id_r;

  logic               keep_owner_s;
  logic               release_s;
  logic               grant_vld_s;
  logic [ID_W-1:0]    grant_s;
  logic [ID_W-1:0]    start_s;
  logic               space_s;
  logic               accept_s;
  logic [CNT_W-1:0]   cnt_next_s;
  logic [NUM_REQ-1:0] ready_s;
  logic [OPW-1:0]     mult_a_s;
  logic [OPW-1:0]     mult_b_s;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] x);
    logic [ID_W-1:0] y;
    if (x == ID_W'(NUM_REQ - 1)) begin
      y = ID_W'(0);
    end else begin
      y = x + ID_W'(1);
    end
    return y;
  endfunction

  // Grant selection: a still-valid owner keeps the grant, otherwise search round-robin
  always_comb begin
    logic [ID_W-1:0] idx;
    logic            hit;
    idx          = ID_W'(0);
    hit          = 1'b0;
    keep_owner_s = owner_vld_r && bus.req_valid[owner_r];
    release_s    = owner_vld_r && !bus.req_valid[owner_r];
    start_s      = owner_vld_r ? wrap_inc(owner_r) : rr_ptr_r;
    grant_vld_s  = keep_owner_s;
    grant_s      = keep_owner_s ? owner_r : ID_W'(0);
    for (int k = 0; k < NUM_REQ; k++) begin
      idx         = ID_W'((int'(start_s) + k) % NUM_REQ);
      hit         = !grant_vld_s && bus.req_valid[idx];
      grant_s     = hit ? idx : grant_s;
      grant_vld_s = grant_vld_s | hit;
    end
  end

  // Handshake, multiplier operand drive and next burst count
  always_comb begin
    space_s    = !res_valid_r || bus.res_ready;
    accept_s   = grant_vld_s && space_s && !rst;
    ready_s    = {NUM_REQ{1'b0}};
    mult_a_s   = {OPW{1'b0}};
    mult_b_s   = {OPW{1'b0}};
    cnt_next_s = keep_owner_s ? (burst_cnt_r + CNT_W'(1)) : CNT_W'(1);
    if (accept_s) begin
      ready_s[grant_s] = 1'b1;
      mult_a_s         = bus.req_a[int'(grant_s)*OPW +: OPW];
      mult_b_s         = bus.req_b[int'(grant_s)*OPW +: OPW];
    end else begin
      ready_s  = {NUM_REQ{1'b0}};
      mult_a_s = {OPW{1'b0}};
      mult_b_s = {OPW{1'b0}};
    end
  end

  // Ownership, burst count and round-robin pointer; a stall leaves all three untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_vld_r <= 1'b0;
      owner_r     <= ID_W'(0);
      burst_cnt_r <= CNT_W'(0);
      rr_ptr_r    <= ID_W'(0);
    end else if (accept_s) begin
      owner_r     <= grant_s;
      burst_cnt_r <= cnt_next_s;
      if (cnt_next_s == CNT_W'(MAX_BURST)) begin
        owner_vld_r <= 1'b0;
        rr_ptr_r    <= wrap_inc(grant_s);
      end else begin
        owner_vld_r <= 1'b1;
        if (release_s) begin
          rr_ptr_r <= wrap_inc(owner_r);
        end
      end
    end else if (release_s) begin
      owner_vld_r <= 1'b0;
      rr_ptr_r    <= wrap_inc(owner_r);
    end
  end

  // One-entry result stage holding the product and the issuing requester
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_r <= 1'b0;
      res_data_r  <= {(2*OPW){1'b0}};
      res_id_r    <= ID_W'(0);
    end else if (accept_s) begin
      res_valid_r <= 1'b1;
      res_data_r  <= bus.mult_out;
      res_id_r    <= grant_s;
    end else if (bus.res_ready) begin
      res_valid_r <= 1'b0;
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.mult_a    = mult_a_s;
  assign bus.mult_b    = mult_b_s;
  assign bus.mult_en   = accept_s;
  assign bus.res_valid = res_valid_r;
  assign bus.res_data  = res_data_r;
  assign bus.res_id    = res_id_r;
endmodule

// File: tb/tb_cmult_rr_scheduler.sv
// Bench for cmult_rr_scheduler: directed vector table for the named corner cases,
// then randomized traffic checked against a queue-free behavioural model.
module tb_cmult_rr_scheduler;
  localparam int W  = 16;
  localparam int N  = 3;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmult_rr_scheduler_if #(.WIDTH_R_I(W), .NUM_REQ(N)) bus ();

  cmult_rr_scheduler #(.WIDTH_R_I(W), .NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [63:0] cmul(input logic [31:0] a, input logic [31:0] b);
    int ar, ai, br, bi;
    logic [31:0] re, im;
    ar = int'($signed(a[31:16]));
    ai = int'($signed(a[15:0]));
    br = int'($signed(b[31:16]));
    bi = int'($signed(b[15:0]));
    re = 32'(ar * br - ai * bi);
    im = 32'(ar * bi + ai * br);
    return {re, im};
  endfunction

  // External combinational multiplier
  assign bus.mult_out = cmul(bus.mult_a, bus.mult_b);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  logic [31:0] op_a [N];
  logic [31:0] op_b [N];

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*32 +: 32] = op_a[i];
      bus.req_b[i*32 +: 32] = op_b[i];
    end
  endtask

  typedef struct {
    logic       rst;
    logic [2:0] rv;
    logic       rr;
    logic [2:0] rdy;
    logic       resv;
    int         id;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input logic r, input logic [2:0] rv, input logic rr,
                     input logic [2:0] rdy, input logic resv, input int id);
    vec_t v;
    v.rst = r; v.rv = rv; v.rr = rr; v.rdy = rdy; v.resv = resv; v.id = id;
    tbl.push_back(v);
  endtask

  // Behavioural model state: current owner (or none), accepts in this burst, search pointer
  int   m_ov, m_owner, m_cnt, m_ptr;
  logic m_rv;
  logic [63:0] m_rd;
  int   m_rid;

  function automatic int pick(input logic [2:0] v);
    int start;
    if (m_ov != 0 && v[m_owner]) return m_owner;
    start = (m_ov != 0) ? (m_owner + 1) % N : m_ptr;
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  initial begin
    rst           = 1'b1;
    bus.req_valid = 3'b000;
    bus.res_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = {16'(2 + i), 16'd4};
      op_b[i] = {16'd1, 16'd2};
    end
    drive_ops();

    // Reset with everything requesting
    repeat (2) add(1'b1, 3'b111, 1'b1, 3'b000, 1'b0, 0);
    // Burst rotation 0,0,0,0,1,1,1,1,2,2,2,2,0
    add(1'b0, 3'b111, 1'b1, 3'b001, 1'b0, 0);
    repeat (3) add(1'b0, 3'b111, 1'b1, 3'b001, 1'b1, 0);
    add(1'b0, 3'b111, 1'b1, 3'b010, 1'b1, 0);
    repeat (3) add(1'b0, 3'b111, 1'b1, 3'b010, 1'b1, 1);
    add(1'b0, 3'b111, 1'b1, 3'b100, 1'b1, 1);
    repeat (3) add(1'b0, 3'b111, 1'b1, 3'b100, 1'b1, 2);
    add(1'b0, 3'b111, 1'b1, 3'b001, 1'b1, 2);
    // Backpressure mid-burst: one held result, no rotation caused by the stall
    repeat (3) add(1'b0, 3'b111, 1'b0, 3'b000, 1'b1, 0);
    repeat (3) add(1'b0, 3'b111, 1'b1, 3'b001, 1'b1, 0);
    add(1'b0, 3'b111, 1'b1, 3'b010, 1'b1, 0);
    // Early release of req0 after two accepts, req1 idle, req2 waiting
    add(1'b0, 3'b001, 1'b1, 3'b001, 1'b1, 1);
    add(1'b0, 3'b101, 1'b1, 3'b001, 1'b1, 0);
    add(1'b0, 3'b100, 1'b1, 3'b100, 1'b1, 0);
    // Reset while req2 owns and a result is pending
    add(1'b1, 3'b111, 1'b1, 3'b000, 1'b1, 2);
    add(1'b0, 3'b111, 1'b1, 3'b001, 1'b0, 0);
    add(1'b0, 3'b000, 1'b1, 3'b000, 1'b1, 0);
    add(1'b0, 3'b000, 1'b1, 3'b000, 1'b0, 0);
    // Sole requester re-wins across its own rotation
    add(1'b0, 3'b010, 1'b1, 3'b010, 1'b0, 0);
    repeat (5) add(1'b0, 3'b010, 1'b1, 3'b010, 1'b1, 1);
    add(1'b0, 3'b000, 1'b1, 3'b000, 1'b1, 1);
    add(1'b0, 3'b000, 1'b1, 3'b000, 1'b0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      int g;
      @(negedge clk);
      rst           = tbl[i].rst;
      bus.req_valid = tbl[i].rv;
      bus.res_ready = tbl[i].rr;
      #1;
      g = tbl[i].rdy[2] ? 2 : (tbl[i].rdy[1] ? 1 : 0);
      chk($sformatf("v%0d req_ready", i), 64'(bus.req_ready), 64'(tbl[i].rdy));
      chk($sformatf("v%0d mult_en", i), 64'(bus.mult_en), 64'(|tbl[i].rdy));
      chk($sformatf("v%0d mult_a", i), 64'(bus.mult_a),
          (|tbl[i].rdy) ? 64'(op_a[g]) : 64'd0);
      chk($sformatf("v%0d res_valid", i), 64'(bus.res_valid), 64'(tbl[i].resv));
      if (tbl[i].resv) begin
        chk($sformatf("v%0d res_id", i), 64'(bus.res_id), 64'(tbl[i].id));
        chk($sformatf("v%0d res_data", i), bus.res_data,
            cmul(op_a[tbl[i].id], op_b[tbl[i].id]));
      end
    end

    // Randomized traffic against the behavioural model
    begin
      logic [2:0] rvv;
      bit known;
      known = 1'b0;
      rvv   = 3'b000;
      m_ov = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_rv = 1'b0; m_rd = 64'd0; m_rid = 0;
      for (int c = 0; c < 3000; c++) begin
        int  g;
        bit  acc;
        @(negedge clk);
        rst = (c < 2) || ($urandom_range(0, 299) == 0);
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(0, 4) == 0) rvv[i] = ~rvv[i];
          op_a[i] = $urandom;
          op_b[i] = $urandom;
        end
        bus.req_valid = rvv;
        bus.res_ready = ($urandom_range(0, 3) != 0);
        drive_ops();
        #1;
        g   = rst ? -1 : pick(rvv);
        acc = (g >= 0) && (!m_rv || bus.res_ready);
        chk($sformatf("r%0d req_ready", c), 64'(bus.req_ready), acc ? 64'(3'b001 << g) : 64'd0);
        chk($sformatf("r%0d mult_en", c), 64'(bus.mult_en), 64'(acc));
        chk($sformatf("r%0d mult_a", c), 64'(bus.mult_a), acc ? 64'(op_a[g]) : 64'd0);
        chk($sformatf("r%0d mult_b", c), 64'(bus.mult_b), acc ? 64'(op_b[g]) : 64'd0);
        if (known) begin
          chk($sformatf("r%0d res_valid", c), 64'(bus.res_valid), 64'(m_rv));
          if (m_rv) begin
            chk($sformatf("r%0d res_id", c), 64'(bus.res_id), 64'(m_rid));
            chk($sformatf("r%0d res_data", c), bus.res_data, m_rd);
          end
        end
        // Advance the model across the coming edge
        if (rst) begin
          m_ov = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_rv = 1'b0; m_rd = 64'd0; m_rid = 0;
          known = 1'b1;
        end else begin
          if (m_ov != 0 && !rvv[m_owner]) begin
            m_ov  = 0;
            m_ptr = (m_owner + 1) % N;
          end
          if (acc) begin
            m_rv  = 1'b1;
            m_rd  = cmul(op_a[g], op_b[g]);
            m_rid = g;
            if (m_ov != 0 && g == m_owner) begin
              m_cnt++;
            end else begin
              m_owner = g;
              m_cnt   = 1;
            end
            if (m_cnt == MB) begin
              m_ov  = 0;
              m_ptr = (g + 1) % N;
            end else begin
              m_ov = 1;
            end
          end else if (bus.res_ready) begin
            m_rv = 1'b0;
          end
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
